// File: rtl/fp_unpack_align_if.sv
// fp_unpack_align_if: operand/result handshake bundle for the FP add/sub front end
// master drives kill, operands and out_ready; slave (the block) returns the unpacked fields.
interface fp_unpack_align_if;
  logic kill;
  logic in_valid;
  logic in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic sub;
  logic out_valid;
  logic out_ready;
  logic sign1;
  logic sign2;
  logic NaN;
  logic inf1;
  logic inf2;
  logic zero1;
  logic zero2;
  logic swap;
  logic [7:0] exp_big;
  logic [23:0] mant_big;
  logic [23:0] mant_small;
  logic [23:0] grs;
  modport master (
    output kill, in_valid, op_a, op_b, sub, out_ready,
    input in_ready, out_valid, sign1, sign2, NaN, inf1, inf2, zero1, zero2, swap,
    input exp_big, mant_big, mant_small, grs
  );
  modport slave (
    input kill, in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, sign1, sign2, NaN, inf1, inf2, zero1, zero2, swap,
    output exp_big, mant_big, mant_small, grs
  );
endinterface

// File: rtl/fp_unpack_align.sv
// fp_unpack_align: binary32 add/sub operand unpack, magnitude ordering and iterative alignment
// clk, reset (sync, active-high); io.slave: kill flush, in_valid/in_ready with op_a/op_b/sub,
// out_valid/out_ready with sign1/sign2, NaN/inf1/inf2/zero1/zero2, swap, exp_big, mant_big,
// mant_small and grs (G, R, sticky field shifted out of mant_small).
module fp_unpack_align #(
  parameter int SHIFT_PER_CYCLE = 8
) (
  input logic clk,
  input logic reset,
  fp_unpack_align_if.slave io
);
  localparam logic [1:0] IDLE = 2'd0, CLASS = 2'd1, ALIGN = 2'd2, DONE = 2'd3;
  localparam logic [5:0] SPC = 6'(SHIFT_PER_CYCLE);
  logic [1:0] state;
  logic [31:0] a, b;
  logic s;
  logic [5:0] rem, d, k;
  logic [7:0] ea_eff, eb_eff, diff;
  logic [23:0] ma, mb;
  logic nan_a, nan_b, inf_a, inf_b, z_a, z_b, b_gt, early;
  logic [47:0] win, shifted, lost;
  always_comb begin
    ea_eff = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eb_eff = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    ma = {a[30:23] != 8'd0, a[22:0]};
    mb = {b[30:23] != 8'd0, b[22:0]};
    nan_a = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    nan_b = (b[30:23] == 8'hFF) && (b[22:0] != '0);
    inf_a = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    inf_b = (b[30:23] == 8'hFF) && (b[22:0] == '0);
    z_a = a[30:0] == '0;
    z_b = b[30:0] == '0;
    // raw {exp,frac} ordering equals significand-magnitude ordering, subnormals included
    b_gt = b[30:0] > a[30:0];
    diff = b_gt ? eb_eff - ea_eff : ea_eff - eb_eff;
    d = (diff > 8'd48) ? 6'd48 : diff[5:0];
    early = nan_a | nan_b | inf_a | inf_b | (z_b & !b_gt) | (z_a & b_gt) | (d == 6'd0);
    k = (rem < SPC) ? rem : SPC;
    win = {io.mant_small, io.grs};
    shifted = win >> k;
    lost = win & ~({48{1'b1}} << k);
  end
  always_ff @(posedge clk) begin
    if (reset || io.kill) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      s <= 1'b0;
      rem <= '0;
      io.sign1 <= 1'b0;
      io.sign2 <= 1'b0;
      io.NaN <= 1'b0;
      io.inf1 <= 1'b0;
      io.inf2 <= 1'b0;
      io.zero1 <= 1'b0;
      io.zero2 <= 1'b0;
      io.swap <= 1'b0;
      io.exp_big <= '0;
      io.mant_big <= '0;
      io.mant_small <= '0;
      io.grs <= '0;
    end else begin
      if (state == IDLE && io.in_valid) begin
        a <= io.op_a;
        b <= io.op_b;
        s <= io.sub;
        state <= CLASS;
      end
      if (state == CLASS) begin
        io.sign1 <= a[31];
        io.sign2 <= b[31] ^ s;
        io.NaN <= nan_a | nan_b;
        io.inf1 <= inf_a;
        io.inf2 <= inf_b;
        io.zero1 <= z_a;
        io.zero2 <= z_b;
        io.swap <= b_gt;
        io.exp_big <= b_gt ? eb_eff : ea_eff;
        io.mant_big <= b_gt ? mb : ma;
        io.mant_small <= b_gt ? ma : mb;
        io.grs <= '0;
        rem <= d;
        state <= early ? DONE : ALIGN;
      end
      // earlier sticky sits in bit 0, so it is part of lost and survives each step
      if (state == ALIGN) begin
        {io.mant_small, io.grs} <= {shifted[47:1], shifted[0] | (|lost)};
        rem <= rem - k;
        if (rem == k) state <= DONE;
      end
      if (state == DONE && io.out_ready) state <= IDLE;
    end
  end
  assign io.in_ready = state == IDLE;
  assign io.out_valid = state == DONE;
endmodule

// File: tb/tb_fp_unpack_align.sv
// tb_fp_unpack_align: directed vectors checked against a behavioural unpack/align model
module tb_fp_unpack_align;
  localparam int S = 8;
  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int failures = 0;
  int lat;
  logic m_s1, m_s2, m_nan, m_i1, m_i2, m_z1, m_z2, m_sw;
  logic [7:0] m_eb;
  logic [23:0] m_mb, m_ms, m_g;
  int m_lat;
  fp_unpack_align_if io();
  fp_unpack_align #(.SHIFT_PER_CYCLE(S)) dut (.clk(clk), .reset(reset), .io(io));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [87:0] outs();
    return {io.sign1, io.sign2, io.NaN, io.inf1, io.inf2, io.zero1, io.zero2, io.swap,
            io.exp_big, io.mant_big, io.mant_small, io.grs};
  endfunction
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s);
    int xa, xb, d;
    logic [23:0] sa, sb;
    logic [47:0] full, res;
    logic sticky, early;
    xa = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
    xb = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
    sa = {a[30:23] != 8'd0, a[22:0]};
    sb = {b[30:23] != 8'd0, b[22:0]};
    m_s1 = a[31];
    m_s2 = b[31] ^ s;
    m_i1 = xa == 255 && sa[22:0] == 0;
    m_i2 = xb == 255 && sb[22:0] == 0;
    m_nan = (xa == 255 && sa[22:0] != 0) || (xb == 255 && sb[22:0] != 0);
    m_z1 = xa == 1 && sa == 0;
    m_z2 = xb == 1 && sb == 0;
    m_sw = (xb > xa) || (xb == xa && sb > sa);
    m_eb = m_sw ? 8'(xb) : 8'(xa);
    m_mb = m_sw ? sb : sa;
    d = m_sw ? xb - xa : xa - xb;
    if (d > 48) d = 48;
    early = m_nan || m_i1 || m_i2 || (m_sw ? m_z1 : m_z2) || d == 0;
    full = {(m_sw ? sa : sb), 24'd0};
    res = early ? full : full >> d;
    sticky = !early && ((res << d) != full);
    m_ms = res[47:24];
    m_g = res[23:0] | {23'd0, sticky};
    m_lat = 2 + (early ? 0 : (d + S - 1) / S);
  endfunction
  always @(negedge clk) begin
    if (!reset && io.out_valid) begin
      chk("in_ready_in_done", io.in_ready, 0);
      chk("sign1", io.sign1, m_s1);
      chk("sign2", io.sign2, m_s2);
      chk("NaN", io.NaN, m_nan);
      chk("inf1", io.inf1, m_i1);
      chk("inf2", io.inf2, m_i2);
      chk("zero1", io.zero1, m_z1);
      chk("zero2", io.zero2, m_z2);
      chk("swap", io.swap, m_sw);
      chk("exp_big", io.exp_big, m_eb);
      chk("mant_big", io.mant_big, m_mb);
      chk("mant_small", io.mant_small, m_ms);
      chk("grs", io.grs, m_g);
    end
  end
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s, output int l);
    model(a, b, s);
    chk("in_ready_before_op", io.in_ready, 1);
    io.op_a = a;
    io.op_b = b;
    io.sub = s;
    io.in_valid = 1;
    @(posedge clk);
    #1 io.in_valid = 0;
    l = 1;
    while (!io.out_valid && l < 100) begin
      @(posedge clk);
      #1 l++;
    end
    chk("latency", l, m_lat);
  endtask
  task automatic finish_op(input int hold);
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    io.out_ready = 1;
    @(posedge clk);
    #1 io.out_ready = 0;
    chk("out_valid_after_hs", io.out_valid, 0);
    chk("in_ready_after_hs", io.in_ready, 1);
  endtask
  initial begin
    io.kill = 0;
    io.in_valid = 0;
    io.op_a = '0;
    io.op_b = '0;
    io.sub = 0;
    io.out_ready = 0;
    repeat (3) @(posedge clk);
    #1 chk("reset_in_ready", io.in_ready, 1);
    chk("reset_out_valid", io.out_valid, 0);
    chk("reset_outs", outs(), 0);
    reset = 0;
    start_op(32'h3F800000, 32'h3F800000, 0, lat);
    chk("t1_lat", lat, 2);
    chk("t1_exp_big", io.exp_big, 8'h7F);
    chk("t1_mant_big", io.mant_big, 24'h800000);
    chk("t1_mant_small", io.mant_small, 24'h800000);
    chk("t1_grs", io.grs, 0);
    chk("t1_swap", io.swap, 0);
    finish_op(0);
    start_op(32'h3F800000, 32'h40400000, 0, lat);
    chk("t2_lat", lat, 3);
    chk("t2_swap", io.swap, 1);
    chk("t2_exp_big", io.exp_big, 8'h80);
    chk("t2_mant_big", io.mant_big, 24'hC00000);
    chk("t2_mant_small", io.mant_small, 24'h400000);
    chk("t2_grs", io.grs, 0);
    finish_op(5);
    start_op(32'h3F800001, 32'h4C000000, 0, lat);
    chk("t3_lat", lat, 6);
    chk("t3_mant_small", io.mant_small, 0);
    chk("t3_grs", io.grs, 24'h400001);
    chk("t3_swap", io.swap, 1);
    finish_op(1);
    start_op(32'h7FC00000, 32'h3F800000, 0, lat);
    chk("t4_lat", lat, 2);
    chk("t4_nan", io.NaN, 1);
    finish_op(0);
    start_op(32'h7F800000, 32'h7F800000, 1, lat);
    chk("t4_inf1", io.inf1, 1);
    chk("t4_inf2", io.inf2, 1);
    chk("t4_sign1", io.sign1, 0);
    chk("t4_sign2", io.sign2, 1);
    finish_op(0);
    start_op(32'h00000001, 32'h3F800000, 0, lat);
    chk("t5_lat", lat, 8);
    chk("t5_mant_small", io.mant_small, 0);
    chk("t5_grs", io.grs, 24'h000001);
    finish_op(0);
    start_op(32'h41200000, 32'hBDCCCCCD, 1, lat);
    finish_op(0);
    start_op(32'h4B800000, 32'h3FFFFFFF, 0, lat);
    finish_op(2);
    start_op(32'h4F800000, 32'h3F800001, 1, lat);
    finish_op(0);
    start_op(32'h57800000, 32'h3FFFFFFF, 0, lat);
    finish_op(0);
    start_op(32'h57000000, 32'h3FFFFFFF, 0, lat);
    finish_op(0);
    start_op(32'h00000000, 32'hC0000000, 0, lat);
    finish_op(0);
    start_op(32'h00400000, 32'h00200000, 0, lat);
    finish_op(0);
    start_op(32'h3F800000, 32'h00000000, 1, lat);
    finish_op(0);
    io.op_a = 32'h3F800001;
    io.op_b = 32'h4C000000;
    io.sub = 0;
    io.in_valid = 1;
    @(posedge clk);
    #1 io.in_valid = 0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 io.kill = 1;
    @(posedge clk);
    #1 io.kill = 0;
    chk("kill_in_ready", io.in_ready, 1);
    chk("kill_out_valid", io.out_valid, 0);
    chk("kill_outs", outs(), 0);
    repeat (8) begin
      @(posedge clk);
      #1 chk("kill_no_out_valid", io.out_valid, 0);
    end
    start_op(32'h3F800000, 32'h40400000, 0, lat);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    chk("reset_done_outs", outs(), 0);
    chk("reset_done_out_valid", io.out_valid, 0);
    chk("reset_done_in_ready", io.in_ready, 1);
    start_op(32'h40400000, 32'h3F800000, 1, lat);
    finish_op(0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
